video_palsched: RTL and testbench
=================================

// Module: video_palsched
// PURPOSE
//  Write scheduler for the 9-bit-addressed, 12-bit {R4,G4,B4} palette RAM in the video path.
//  - Arbitrates between ATM palette writes (CPU OUT, 16 entries) and ULAplus writes (64 entries at 0x100+).
//  - Buffers requests and issues at most one RAM write per cycle, only in cycles where hold is low
//    (hold high means the read port is serving visible pixels).
//  - After reset, an init sequencer loads the default palette before servicing CPU writes.
// PARAMETERS
//  UP_FIFO_DEPTH  4   ULAplus write queue depth; power of two, >=2
//  INIT_ULAPLUS   1   1: init also zeroes entries 0x100..0x13F; 0: init loads 0x000..0x00F only
//  WR_ANYTIME     0   1: ignore hold, so writes may issue in any cycle
// PORTS
//  clk        in   1   28 MHz video clock
//  rst_n      in   1   asynchronous active-low reset
//  hold       in   1   1 = no RAM write allowed this cycle (active display)
//  atm_req    in   1   1-cycle strobe: ATM palette write
//  atm_addr   in   4   ATM entry index {bright,G,R,B}
//  atm_data   in  12   ATM colour {R4,G4,B4}, already expanded by caller
//  up_req     in   1   1-cycle strobe: ULAplus palette write
//  up_addr    in   6   ULAplus entry 0..63
//  up_data    in   8   ULAplus colour GGGRRRBB
//  pal_we     out  1   palette RAM write enable
//  pal_addr   out  9   palette RAM write address
//  pal_data   out 12   palette RAM write data {R4,G4,B4}
//  init_done  out  1   1 once the init sequence is complete; stays 1 until reset
//  busy       out  1   1 while init is running, an ATM write is pending, or the FIFO is non-empty
//  atm_ovf    out  1   1-cycle pulse: a pending ATM write was overwritten
//  up_ovf     out  1   1-cycle pulse: a ULAplus write was dropped because the FIFO was full
// BEHAVIOUR
//  Reset: all outputs registered.
//  - pal_we=0, pal_addr=0, pal_data=0, init_done=0, busy=1, atm_ovf=0, up_ovf=0.
//  - FSM goes to INIT with init_cnt=0, FIFO empty, ATM slot empty.
//  - Reset asserted mid-operation aborts everything; no partial write is completed.
//  FSM INIT:
//  - Each cycle with hold=0: write entry init_cnt, then init_cnt+1.
//  - Entries 0..15: each of G/R/B = (bit ? (idx[3] ? 4'hF : 4'hA) : 4'h0).
//  - Entries 16..79 (INIT_ULAPLUS=1): addr 0x100+(cnt-16), data 12'h000.
//  - After the last entry, go to RUN and set init_done=1 in the same cycle as the last pal_we.
//  - CPU requests arriving during INIT are captured (ATM slot / FIFO) and not lost.
//  FSM RUN, per cycle with hold=0 (WR_ANYTIME=1 treats hold as 0):
//  - Priority: ATM slot > FIFO head.
//  - The winner is issued; its slot or entry frees in the same cycle.
//  - hold=1: pal_we=0 and nothing is popped.
//  Latency: a request strobed in cycle N with nothing ahead of it and hold=0 in N+1 gives pal_we=1 in N+1.
//  ATM slot: single register {valid, addr, data}.
//  - atm_req with slot valid and not being issued this cycle: overwrite (last wins), atm_ovf=1.
//  - atm_req in the cycle the slot issues: the new value is loaded, no ovf.
//  - ATM write address is {5'd0, atm_addr}.
//  ULAplus FIFO: push on up_req; pop when issued.
//  - Push on full is accepted only if a pop happens the same cycle; otherwise drop and up_ovf=1.
//  - Pointers are log2(DEPTH) bits, wrap modulo DEPTH; separate count of log2(DEPTH)+1 bits.
//  - Push and pop on empty: the entry is stored and issued no earlier than next cycle (no bypass).
//  - Data expansion: R4={R3,R3[2]}, G4={G3,G3[2]}, B4={B2,B2}.
//  - Address is {3'b100, up_addr}.
//  busy = (state==INIT) | atm_valid | (fifo_count!=0), registered.
//  Simultaneous atm_req and up_req are both captured in the same cycle.
// STRUCTURE
//  Shared package (video defs include):
//  - FSM state codes ST_INIT/ST_RUN
//  - palette base constants PAL_ATM_BASE=9'h000, PAL_UP_BASE=9'h100
//  - default-colour levels LVL_BRIGHT=4'hF, LVL_NORM=4'hA
//  One sub-module, video_palsched_fifo: synchronous FIFO (DEPTH param, 14-bit entry {addr6, data8}) with
//  full/empty/count outputs.
//  Arbitration, init counter and expansion stay in the top level.
// TESTING
//  1 Reset released, hold=0 -> 80 consecutive pal_we; entry 0x00F=12'hFFF, 0x001=12'h00A,
//    0x13F=12'h000; init_done=1 in cycle 80.
//  2 After init, atm_req addr=5 data=12'h123, hold=0 -> next cycle pal_we=1, pal_addr=9'h005,
//    pal_data=12'h123.
//  3 up_req addr=6'h3F data=8'b111_010_01 -> pal_addr=9'h13F, pal_data=12'h4F5 (R=0100, G=1111, B=0101).
//  4 hold=1, then 5 up_req (DEPTH=4) -> 5th gives up_ovf pulse; releasing hold gives 4 writes in
//    FIFO order.
//  5 hold=1, atm_req twice (data A then B) -> atm_ovf once; on hold=0 only B is written, before any
//    queued ULAplus entry.
//  6 rst_n pulled low during INIT at cnt=40 -> outputs return to reset values immediately; restart
//    from entry 0.

Source files
------------

// File: rtl/video_palsched_pkg.sv
// rtl/video_palsched_pkg.sv - shared definitions for the palette write scheduler
package video_palsched_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } pal_state_t;

    localparam logic [8:0] PAL_ATM_BASE = 9'h000;
    localparam logic [8:0] PAL_UP_BASE  = 9'h100;
    localparam logic [3:0] LVL_BRIGHT   = 4'hF;
    localparam logic [3:0] LVL_NORM     = 4'hA;

    typedef struct packed {
        logic [5:0] addr;
        logic [7:0] data;
    } up_entry_t;

    // Index layout is {bright, G, R, B}; colour layout is {R4, G4, B4}.
    function automatic logic [11:0] default_colour(input logic [3:0] idx);
        logic [3:0] lvl;
        lvl = idx[3] ? LVL_BRIGHT : LVL_NORM;
        return {idx[1] ? lvl : 4'h0, idx[2] ? lvl : 4'h0, idx[0] ? lvl : 4'h0};
    endfunction

    // GGGRRRBB -> {R3,R3[2], G3,G3[2], B2,B2}
    function automatic logic [11:0] up_expand(input logic [7:0] d);
        return {d[4:2], d[4], d[7:5], d[7], d[1:0], d[1:0]};
    endfunction

endpackage

// File: rtl/video_palsched_fifo.sv
// rtl/video_palsched_fifo.sv - synchronous FIFO holding queued ULAplus writes
module video_palsched_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 14
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [W-1:0]               push_data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push on full only lands when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
            else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/video_palsched.sv
// rtl/video_palsched.sv - palette RAM write scheduler with default-palette init
module video_palsched
    import video_palsched_pkg::*;
#(
    parameter int UP_FIFO_DEPTH = 4,
    parameter bit INIT_ULAPLUS  = 1'b1,
    parameter bit WR_ANYTIME    = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  logic        atm_req,
    input  logic [3:0]  atm_addr,
    input  logic [11:0] atm_data,
    input  logic        up_req,
    input  logic [5:0]  up_addr,
    input  logic [7:0]  up_data,
    output logic        pal_we,
    output logic [8:0]  pal_addr,
    output logic [11:0] pal_data,
    output logic        init_done,
    output logic        busy,
    output logic        atm_ovf,
    output logic        up_ovf
);
    localparam int CW        = $clog2(UP_FIFO_DEPTH) + 1;
    localparam int INIT_LAST = INIT_ULAPLUS ? 79 : 15;

    pal_state_t  state_q, state_d;
    logic [6:0]  init_cnt_q;
    logic        atm_valid_q, atm_valid_d;
    logic [3:0]  atm_addr_q;
    logic [11:0] atm_data_q;
    logic        pal_we_q, init_done_q, busy_q, atm_ovf_q, up_ovf_q;
    logic [8:0]  pal_addr_q;
    logic [11:0] pal_data_q;

    logic          can_wr, atm_issue, fifo_pop, fifo_push, init_last;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count, fifo_cnt_d;
    up_entry_t     fifo_head;
    logic [8:0]    init_addr;
    logic [11:0]   init_data;

    video_palsched_fifo #(
        .DEPTH(UP_FIFO_DEPTH),
        .W    (14)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (fifo_push),
        .push_data_i({up_addr, up_data}),
        .pop_i      (fifo_pop),
        .head_o     (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    always_comb begin
        can_wr    = WR_ANYTIME ? 1'b1 : ~hold;
        // ATM slot always beats the ULAplus queue.
        atm_issue = (state_q == ST_RUN) & can_wr & atm_valid_q;
        fifo_pop  = (state_q == ST_RUN) & can_wr & ~atm_valid_q & ~fifo_empty;
        fifo_push = up_req & (~fifo_full | fifo_pop);
        fifo_cnt_d = fifo_count + CW'(fifo_push) - CW'(fifo_pop);

        init_last = (init_cnt_q == 7'(INIT_LAST));
        if (init_cnt_q < 7'd16) begin
            init_addr = PAL_ATM_BASE | {5'd0, init_cnt_q[3:0]};
            init_data = default_colour(init_cnt_q[3:0]);
        end else begin
            init_addr = PAL_UP_BASE + {2'b00, init_cnt_q - 7'd16};
            init_data = 12'h000;
        end

        state_d = state_q;
        if (state_q == ST_INIT && can_wr && init_last) state_d = ST_RUN;
        atm_valid_d = atm_req | (atm_valid_q & ~atm_issue);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            atm_valid_q <= 1'b0;
            atm_addr_q  <= '0;
            atm_data_q  <= '0;
            pal_we_q    <= 1'b0;
            pal_addr_q  <= '0;
            pal_data_q  <= '0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b1;
            atm_ovf_q   <= 1'b0;
            up_ovf_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            atm_valid_q <= atm_valid_d;
            busy_q      <= (state_d == ST_INIT) | atm_valid_d | (fifo_cnt_d != '0);
            atm_ovf_q   <= atm_req & atm_valid_q & ~atm_issue;
            up_ovf_q    <= up_req & ~fifo_push;
            if (atm_req) begin
                atm_addr_q <= atm_addr;
                atm_data_q <= atm_data;
            end

            pal_we_q <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    if (can_wr) begin
                        pal_we_q   <= 1'b1;
                        pal_addr_q <= init_addr;
                        pal_data_q <= init_data;
                        init_cnt_q <= init_cnt_q + 7'd1;
                        if (init_last) init_done_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (atm_issue) begin
                        pal_we_q   <= 1'b1;
                        pal_addr_q <= PAL_ATM_BASE | {5'd0, atm_addr_q};
                        pal_data_q <= atm_data_q;
                    end else if (fifo_pop) begin
                        pal_we_q   <= 1'b1;
                        pal_addr_q <= PAL_UP_BASE | {3'b000, fifo_head.addr};
                        pal_data_q <= up_expand(fifo_head.data);
                    end
                end
                default: ;
            endcase
        end
    end

    assign pal_we    = pal_we_q;
    assign pal_addr  = pal_addr_q;
    assign pal_data  = pal_data_q;
    assign init_done = init_done_q;
    assign busy      = busy_q;
    assign atm_ovf   = atm_ovf_q;
    assign up_ovf    = up_ovf_q;

endmodule

// File: tb/tb_video_palsched.sv
// tb/tb_video_palsched.sv - scoreboard bench for video_palsched
module tb_video_palsched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hold = 1'b0;
    logic        atm_req = 1'b0;
    logic [3:0]  atm_addr = '0;
    logic [11:0] atm_data = '0;
    logic        up_req = 1'b0;
    logic [5:0]  up_addr = '0;
    logic [7:0]  up_data = '0;
    logic        pal_we, init_done, busy, atm_ovf, up_ovf;
    logic [8:0]  pal_addr;
    logic [11:0] pal_data;

    always #5 clk = ~clk;

    video_palsched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (hold),
        .atm_req  (atm_req),
        .atm_addr (atm_addr),
        .atm_data (atm_data),
        .up_req   (up_req),
        .up_addr  (up_addr),
        .up_data  (up_data),
        .pal_we   (pal_we),
        .pal_addr (pal_addr),
        .pal_data (pal_data),
        .init_done(init_done),
        .busy     (busy),
        .atm_ovf  (atm_ovf),
        .up_ovf   (up_ovf)
    );

    int n_cmp = 0;
    int n_fail = 0;
    logic [20:0] exp_q[$];
    logic [11:0] mem [512];
    int wr_since_rst = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] dflt(input int i);
        logic [3:0] lvl;
        lvl = (i >= 8) ? 4'hF : 4'hA;
        return {((i & 2) != 0) ? lvl : 4'h0, ((i & 4) != 0) ? lvl : 4'h0,
                ((i & 1) != 0) ? lvl : 4'h0};
    endfunction

    task automatic push_init_exp();
        for (int i = 0; i < 80; i++) begin
            if (i < 16) exp_q.push_back({9'(i), dflt(i)});
            else        exp_q.push_back({9'h100 + 9'(i - 16), 12'h000});
        end
    endtask

    // Monitor: pops the scoreboard on every palette write.
    initial begin
        logic [20:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wr_since_rst = 0;
            end else if (pal_we) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0h data %0h required none", pal_addr, pal_data);
                end else begin
                    e = exp_q.pop_front();
                    check("write", {11'd0, pal_addr, pal_data}, {11'd0, e});
                end
                if (wr_since_rst < 80)
                    check("init_done_at_write", {31'd0, init_done}, {31'd0, wr_since_rst == 79});
                mem[pal_addr] = pal_data;
                wr_since_rst++;
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check("reset_outputs", {6'd0, pal_we, pal_addr, pal_data, init_done, busy, atm_ovf, up_ovf},
              {6'd0, 1'b0, 9'h000, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0});

        // Abort init after 40 entries
        push_init_exp();
        rst_n = 1'b1;
        repeat (40) tick();
        @(negedge clk);
        #1;
        check("partial_writes", 32'(wr_since_rst), 32'd40);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {6'd0, pal_we, pal_addr, pal_data, init_done, busy, atm_ovf, up_ovf},
              {6'd0, 1'b0, 9'h000, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0});
        check("remaining_init_exp", 32'(exp_q.size()), 32'd40);
        exp_q.delete();
        repeat (2) tick();

        // Full init from entry 0
        push_init_exp();
        rst_n = 1'b1;
        repeat (80) tick();
        check("init_done_after_80", {31'd0, init_done}, 32'd1);
        @(negedge clk);
        check("init_write_count", 32'(wr_since_rst), 32'd80);
        check("init_exp_drained", 32'(exp_q.size()), 32'd0);
        check("entry_00f", {20'd0, mem[9'h00F]}, 32'hFFF);
        check("entry_001", {20'd0, mem[9'h001]}, 32'h00A);
        check("entry_13f", {20'd0, mem[9'h13F]}, 32'h000);
        tick();
        check("idle_no_we", {31'd0, pal_we}, 32'd0);
        check("idle_not_busy", {31'd0, busy}, 32'd0);

        // ATM write latency
        atm_req = 1'b1; atm_addr = 4'd5; atm_data = 12'h123;
        exp_q.push_back({9'h005, 12'h123});
        tick();
        atm_req = 1'b0;
        check("busy_atm_pending", {31'd0, busy}, 32'd1);
        tick();
        check("atm_latency", {22'd0, pal_we, pal_addr}, {22'd0, 1'b1, 9'h005});
        tick();
        check("atm_single_we", {31'd0, pal_we}, 32'd0);

        // ULAplus write latency and expansion
        up_req = 1'b1; up_addr = 6'h3F; up_data = 8'hE9;
        exp_q.push_back({9'h13F, 12'h4F5});
        tick();
        up_req = 1'b0;
        tick();
        check("up_latency", {10'd0, pal_we, pal_addr, pal_data}, {10'd0, 1'b1, 9'h13F, 12'h4F5});
        tick();

        // FIFO overflow under hold
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            up_req = 1'b1;
            up_addr = 6'(i + 1);
            case (i)
                0: up_data = 8'h00;
                1: up_data = 8'hFF;
                2: up_data = 8'b001_000_00;
                3: up_data = 8'b000_100_10;
                default: up_data = 8'h55;
            endcase
            tick();
            check("up_ovf_pulse", {31'd0, up_ovf}, {31'd0, i == 4});
        end
        up_req = 1'b0;
        tick();
        check("up_ovf_clear", {31'd0, up_ovf}, 32'd0);
        check("hold_no_we", {31'd0, pal_we}, 32'd0);
        check("hold_busy", {31'd0, busy}, 32'd1);
        exp_q.push_back({9'h101, 12'h000});
        exp_q.push_back({9'h102, 12'hFFF});
        exp_q.push_back({9'h103, 12'h020});
        exp_q.push_back({9'h104, 12'h90A});
        hold = 1'b0;
        repeat (6) tick();
        check("fifo_drained", 32'(exp_q.size()), 32'd0);
        check("fifo_not_busy", {31'd0, busy}, 32'd0);

        // ATM overwrite, simultaneous capture, priority over FIFO
        hold = 1'b1;
        atm_req = 1'b1; atm_addr = 4'd2; atm_data = 12'hAAA;
        up_req = 1'b1; up_addr = 6'h0A; up_data = 8'h03;
        tick();
        check("atm_ovf_first", {31'd0, atm_ovf}, 32'd0);
        atm_addr = 4'd3; atm_data = 12'hBBB;
        up_req = 1'b0;
        tick();
        check("atm_ovf_second", {31'd0, atm_ovf}, 32'd1);
        atm_req = 1'b0;
        tick();
        check("atm_ovf_clear", {31'd0, atm_ovf}, 32'd0);
        exp_q.push_back({9'h003, 12'hBBB});
        exp_q.push_back({9'h10A, 12'h00F});
        hold = 1'b0;
        repeat (4) tick();
        check("prio_drained", 32'(exp_q.size()), 32'd0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
